// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage: issues loads/stores to a data memory with a
// request/acknowledge handshake, aligns store data, extracts and extends load
// data, and produces the MEM/WB register.
//
// Build option: MEM_MISALIGN_TRAP_EN
//   defined   : a misaligned halfword (addr[0]=1) or word (addr[1:0]!=0)
//               access skips the memory and completes with err=1.
//   undefined : misaligned low address bits are forced to zero and the access
//               proceeds normally; err only reports a timeout.
//
// Parameter
//   WAIT_MAX      : BUSY cycles to wait for dm_ack before timing out (1..255)
//
// Ports
//   clk, rst      : clock, synchronous active-low reset
//   valid_in ...  : EX/MEM register contents (alu_out_in is the byte address
//                   for memory ops; funct3_in selects access size/extension)
//   dm_*          : data-memory request side (dm_req held until ack/timeout)
//   stall         : upstream pipeline registers must hold
//   wb_*          : MEM/WB register; wb_valid is a one-cycle pulse
//   err           : one-cycle fault pulse, coincident with wb_valid
//   fsm_state     : current FSM state (debug observation)
//
// Handshake: dm_req is high for every BUSY cycle; the access completes in the
// cycle where dm_ack is sampled high, and dm_rdata is only looked at in that
// cycle. dm_ack is ignored whenever no request is outstanding.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic        err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Timeout fires in the WAIT_MAX-th BUSY cycle, so dm_req is high exactly
  // WAIT_MAX cycles when no acknowledge arrives.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt;

  // Latched access attributes, needed when the load data comes back.
  logic        op_load;
  logic        op_byte;
  logic        op_half;
  logic        op_unsigned;
  logic [1:0]  op_off;
  logic        op_reg_write;
  logic [31:0] op_addr;
  logic [31:0] op_pc;
  logic [4:0]  op_rd;

  // Incoming access decode. Codes other than B/H/BU/HU act as word.
  logic        mem_op;
  logic        in_byte;
  logic        in_half;
  logic [1:0]  in_off;
  logic        trap;
  logic        timeout_hit;
  logic [31:0] rdata_shift;
  logic [31:0] load_data;

  assign mem_op  = valid_in & (mem_read_in | mem_write_in);
  assign in_byte = (funct3_in[1:0] == 2'b00);
  assign in_half = (funct3_in[1:0] == 2'b01);

  // Effective lane offset: halfwords ignore addr[0], words ignore addr[1:0].
  assign in_off  = in_byte ? alu_out_in[1:0] :
                   in_half ? {alu_out_in[1], 1'b0} : 2'b00;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op &
                ((in_half & alu_out_in[0]) |
                 (~in_byte & ~in_half & (alu_out_in[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign timeout_hit = (wait_cnt == WAIT_LAST);

  // Load data: shift the addressed lane down, then extend by size.
  assign rdata_shift = dm_rdata >> {op_off, 3'b000};

  always_comb begin
    load_data = dm_rdata;
    if (op_byte) begin
      load_data = {{24{~op_unsigned & rdata_shift[7]}}, rdata_shift[7:0]};
    end else if (op_half) begin
      load_data = {{16{~op_unsigned & rdata_shift[15]}}, rdata_shift[15:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    dm_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          state_d = trap ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall  = 1'b1;
        dm_req = 1'b1;
        // An acknowledge in the final wait cycle still counts as success.
        if (dm_ack || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fsm_state = state_q;

  // ---------------------------------------------------------------------------
  // Datapath: request registers, wait counter and MEM/WB register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt     <= 8'd0;
      op_load      <= 1'b0;
      op_byte      <= 1'b0;
      op_half      <= 1'b0;
      op_unsigned  <= 1'b0;
      op_off       <= 2'b00;
      op_reg_write <= 1'b0;
      op_addr      <= 32'd0;
      op_pc        <= 32'd0;
      op_rd        <= 5'd0;
      dm_we        <= 1'b0;
      dm_addr      <= 32'd0;
      dm_be        <= 4'd0;
      dm_wdata     <= 32'd0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_data      <= 32'd0;
      wb_pc        <= 32'd0;
      wb_rd        <= 5'd0;
      err          <= 1'b0;
    end else begin
      // Pulses default low; other wb_* fields hold.
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in && !mem_op) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_in;
            wb_data      <= alu_out_in;
            wb_pc        <= pc_in;
            wb_rd        <= rd_in;
          end else if (trap) begin
            wb_valid     <= 1'b1;
            err          <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_data      <= alu_out_in;
            wb_pc        <= pc_in;
            wb_rd        <= rd_in;
          end else if (mem_op) begin
            wait_cnt     <= 8'd0;
            // A simultaneous read+write request is a store.
            op_load      <= ~mem_write_in;
            op_byte      <= in_byte;
            op_half      <= in_half;
            op_unsigned  <= funct3_in[2];
            op_off       <= in_off;
            op_reg_write <= reg_write_in;
            op_addr      <= alu_out_in;
            op_pc        <= pc_in;
            op_rd        <= rd_in;
            dm_we        <= mem_write_in;
            dm_addr      <= {alu_out_in[31:2], 2'b00};
            if (in_byte) begin
              dm_be    <= 4'b0001 << in_off;
              dm_wdata <= {4{rs2_data_in[7:0]}};
            end else if (in_half) begin
              dm_be    <= 4'b0011 << in_off;
              dm_wdata <= {2{rs2_data_in[15:0]}};
            end else begin
              dm_be    <= 4'b1111;
              dm_wdata <= rs2_data_in;
            end
          end
        end
        BUSY: begin
          if (dm_ack) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= op_reg_write;
            wb_data      <= op_load ? load_data : op_addr;
            wb_pc        <= op_pc;
            wb_rd        <= op_rd;
          end else if (timeout_hit) begin
            wb_valid     <= 1'b1;
            err          <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_data      <= op_addr;
            wb_pc        <= op_pc;
            wb_rd        <= op_rd;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage. Directed scenarios plus a
// randomized run, all compared against a behavioural model of the access rules
// (lane selection, byte enables, extension, wait/timeout behaviour).
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_out_in;
  logic [31:0] rs2_data_in;
  logic [31:0] pc_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        reg_write_in;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [4:0]  wb_rd;
  logic        err;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  mem_stage #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_out_in(alu_out_in),
    .rs2_data_in(rs2_data_in), .pc_in(pc_in), .rd_in(rd_in),
    .funct3_in(funct3_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall(stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .wb_pc(wb_pc), .wb_rd(wb_rd), .err(err),
    .fsm_state(fsm_state)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Access size in bytes from funct3; unlisted codes are word accesses.
  function automatic int ref_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % ref_bytes(f3)) != 0;
  endfunction

  // Byte offset actually used: rounded down to a multiple of the size.
  function automatic int ref_off(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = ref_bytes(f3);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < ref_bytes(f3); i++) be[ref_off(f3, a) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (ref_bytes(f3))
      1:       return d[7:0] * 32'h0101_0101;
      2:       return d[15:0] * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    int          n;
    n = ref_bytes(f3);
    v = rd >> (8 * ref_off(f3, a));
    if (n == 4) return rd;
    v = v % (32'd1 << (8 * n));
    // Signed forms: subtract 2^bits when the top bit of the field is set.
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (32'd1 << (8 * n - 1)))
      v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // ---------------------------------------------------------------- driver
  // ack_at: BUSY cycle (1-based) in which dm_ack is pulsed; 0 = never.
  task automatic run_op(input logic mr, input logic mw, input logic rw,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [31:0] pc,
                        input logic [4:0] rd, input int ack_at,
                        input logic [31:0] rdata);
    bit memop, trap_exp, timed_out, done;
    memop = mr | mw;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_exp = memop && ref_misaligned(f3, a);
`else
    trap_exp = 1'b0;
`endif
    @(negedge clk);
    valid_in = 1'b1; alu_out_in = a; rs2_data_in = rs2; pc_in = pc; rd_in = rd;
    funct3_in = f3; mem_read_in = mr; mem_write_in = mw; reg_write_in = rw;
    #1;
    chk("stall_issue", stall, memop);
    @(negedge clk);
    valid_in = 1'b0;
    if (!memop || trap_exp) begin
      chk("wb_valid", wb_valid, 1);
      chk("err", err, trap_exp);
      chk("wb_reg_write", wb_reg_write, trap_exp ? 1'b0 : rw);
      chk("wb_pc", wb_pc, pc);
      chk("wb_rd", wb_rd, rd);
      chk("stall_wb", stall, 0);
      chk("dm_req_wb", dm_req, 0);
      if (!memop) chk("wb_data", wb_data, a);
      @(negedge clk);
      chk("wb_valid_drop", wb_valid, 0);
      chk("err_drop", err, 0);
      if (!memop) chk("wb_data_hold", wb_data, a);
      return;
    end
    timed_out = (ack_at == 0 || ack_at > WAIT_MAX);
    done = 1'b0;
    for (int i = 1; i <= WAIT_MAX && !done; i++) begin
      chk("dm_req_busy", dm_req, 1);
      chk("stall_busy", stall, 1);
      chk("wb_valid_busy", wb_valid, 0);
      if (i == 1) begin
        chk("dm_we", dm_we, mw);
        chk("dm_addr", dm_addr, {a[31:2], 2'b00});
        chk("dm_be", dm_be, mw ? ref_be(f3, a) : dm_be_any(f3, a));
        if (mw) chk("dm_wdata", dm_wdata, ref_wdata(f3, rs2));
      end
      if (i == ack_at) begin
        dm_ack = 1'b1; dm_rdata = rdata;
      end
      @(negedge clk);
      dm_ack = 1'b0; dm_rdata = $urandom;
      if (i == ack_at) done = 1'b1;
    end
    chk("dm_req_done", dm_req, 0);
    chk("stall_done", stall, 0);
    chk("wb_valid_done", wb_valid, 1);
    chk("err_done", err, timed_out);
    chk("wb_reg_write_done", wb_reg_write, timed_out ? 1'b0 : rw);
    chk("wb_pc_done", wb_pc, pc);
    chk("wb_rd_done", wb_rd, rd);
    if (!timed_out)
      chk("wb_data_done", wb_data, (mr && !mw) ? ref_load(f3, a, rdata) : a);
    @(negedge clk);
    chk("wb_valid_drop", wb_valid, 0);
    chk("err_drop", err, 0);
  endtask

  // Byte enables for loads follow the same lane rule as stores.
  function automatic logic [3:0] dm_be_any(input logic [2:0] f3, input logic [31:0] a);
    return ref_be(f3, a);
  endfunction

  // ---------------------------------------------------------------- stimulus
  logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

  initial begin
    rst = 1'b0; valid_in = 1'b0; alu_out_in = '0; rs2_data_in = '0; pc_in = '0;
    rd_in = '0; funct3_in = '0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    reg_write_in = 1'b0; dm_rdata = '0; dm_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_dm_be", dm_be, 0);
    chk("rst_wb_data", wb_data, 0);
    rst = 1'b1;

    // Non-memory instruction
    run_op(0, 0, 1, 3'b010, 32'h55, 32'h0, 32'h1000, 5'd3, 0, 32'h0);
    // LB at 0x103, ack in the 2nd BUSY cycle
    run_op(1, 0, 1, 3'b000, 32'h103, 32'h0, 32'h1004, 5'd4, 2, 32'h8000_0000);
    chk("lb_const", wb_data, 32'hFFFF_FF80);
    // SH at 0x202
    run_op(0, 1, 0, 3'b001, 32'h202, 32'h1234_ABCD, 32'h1008, 5'd0, 1, 32'h0);
    chk("sh_be_const", dm_be, 4'b1100);
    chk("sh_wdata_const", dm_wdata, 32'hABCD_ABCD);
    // Read+write together is a store
    run_op(1, 1, 0, 3'b000, 32'h301, 32'h0000_00A5, 32'h100C, 5'd1, 3, 32'h0);
    // LW never acknowledged -> timeout
    run_op(1, 0, 1, 3'b010, 32'h400, 32'h0, 32'h1010, 5'd7, 0, 32'h0);
    // Ack exactly at the timeout limit
    run_op(1, 0, 1, 3'b100, 32'h402, 32'h0, 32'h1014, 5'd8, WAIT_MAX, 32'h00F1_0000);
    // Misaligned LW
    run_op(1, 0, 1, 3'b010, 32'h101, 32'h0, 32'h1018, 5'd9, 1, 32'hCAFE_BABE);
    // Unsigned half load, upper lane
    run_op(1, 0, 1, 3'b101, 32'h506, 32'h0, 32'h101C, 5'd10, 2, 32'h9876_0000);

    // dm_ack outside BUSY is ignored
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("stray_ack_wb_valid", wb_valid, 0);
    chk("stray_ack_dm_req", dm_req, 0);

    // Reset in the 2nd BUSY cycle abandons the access
    @(negedge clk);
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
    alu_out_in = 32'h600; reg_write_in = 1'b1; pc_in = 32'h2000; rd_in = 5'd5;
    @(negedge clk);
    valid_in = 1'b0;
    chk("abandon_busy1", dm_req, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abandon_dm_req", dm_req, 0);
    chk("abandon_stall", stall, 0);
    chk("abandon_wb_valid", wb_valid, 0);
    chk("abandon_dm_addr", dm_addr, 0);
    chk("abandon_dm_we", dm_we, 0);
    chk("abandon_wb_pc", wb_pc, 0);
    chk("abandon_err", err, 0);
    rst = 1'b1;
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abandon_no_wb", wb_valid, 0);
      @(negedge clk);
    end

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      int kind, ack;
      logic [2:0] f3;
      kind = $urandom_range(0, 3);
      f3   = f3_tab[$urandom_range(0, 7)];
      ack  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, WAIT_MAX);
      case (kind)
        0: run_op(0, 0, 1'($urandom), f3, $urandom, $urandom, $urandom, 5'($urandom), 0, 0);
        1: run_op(1, 0, 1'($urandom), f3, $urandom, $urandom, $urandom, 5'($urandom), ack, $urandom);
        2: run_op(0, 1, 1'($urandom), f3, $urandom, $urandom, $urandom, 5'($urandom), ack, $urandom);
        default: run_op(1, 1, 1'($urandom), f3, $urandom, $urandom, $urandom, 5'($urandom), ack, $urandom);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: WAIT_MAX, 15, max BUSY cycles awaiting dm_ack before timeout (1..255).
REQ-002 clk  in  1  rising-edge clock, the block's only clock.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 valid_in  in  1  EX/MEM register holds a live instruction.
REQ-005 alu_out_in  in  32  ALU result; byte address for loads and stores.
REQ-006 rs2_data_in  in  32  store data.
REQ-007 pc_in  in  32  instruction PC.
REQ-008 rd_in  in  5  destination register.
REQ-009 funct3_in  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-010 mem_read_in, mem_write_in, reg_write_in  in  1 each  load, store and register-writeback controls.
REQ-011 dm_req  out  1  data-memory request, held until dm_ack or timeout.
REQ-012 dm_we  out  1  store when 1, load when 0.
REQ-013 dm_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-014 dm_be  out  4  byte enables.
REQ-015 dm_wdata  out  32  lane-replicated store data.
REQ-016 dm_rdata  in  32  load data, valid with dm_ack.
REQ-017 dm_ack  in  1  one-cycle completion pulse.
REQ-018 stall  out  1  upstream registers hold.
REQ-019 wb_valid, wb_reg_write  out  1 each  MEM/WB valid (one-cycle pulse) and writeback enable.
REQ-020 wb_data, wb_pc  out  32 each  load result or ALU result; PC.
REQ-021 wb_rd  out  5  destination register.
REQ-022 err  out  1  one-cycle fault pulse, coincident with wb_valid.

Function
REQ-023 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-024 IDLE, valid_in, no memory op: at the next edge wb_* load alu_out_in, pc_in, rd_in and reg_write_in, wb_valid=1, stall=0 (1-cycle latency).
REQ-025 IDLE, valid_in, mem_read_in or mem_write_in: stall=1 combinationally, inputs latched at the edge, next state BUSY.
REQ-026 mem_read_in and mem_write_in both 1: treated as a store.
REQ-027 BUSY: dm_req=1 and stall=1; the timeout counter increments each BUSY cycle without dm_ack.
REQ-028 BUSY, dm_ack=1: wb_* loaded at that edge, next state DONE; dm_ack in the same cycle as the timeout limit counts as success.
REQ-029 BUSY, counter reaches WAIT_MAX with no dm_ack: dm_req drops, next state DONE, err=1, wb_reg_write=0.
REQ-030 DONE: stall=0 and wb_valid=1 for one cycle; inputs are ignored; next state IDLE unconditionally.
REQ-031 valid_in=0 in IDLE: wb_valid=0; other wb_* hold their values.
REQ-032 Store enables: SB dm_be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH dm_be=4'b0011<<{addr[1],0}, wdata={2{rs2[15:0]}}; SW dm_be=4'b1111, wdata=rs2.
REQ-033 Loads select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes 32 bits.
REQ-034 dm_ack outside BUSY SHALL be ignored.

Reset
REQ-035 rst=0 at an edge: state=IDLE, counter=0, and dm_req, dm_we, dm_addr, dm_be, dm_wdata, stall, err and all wb_* are 0.
REQ-036 Reset during BUSY abandons the access: dm_req=0 from the next cycle and no wb_valid for that access.

Configuration
REQ-037 MEM_MISALIGN_TRAP_EN defined: a misaligned H (addr[0]=1) or W (addr[1:0]!=0) access issues no dm_req, goes IDLE->DONE with err=1 and wb_reg_write=0.
REQ-038 MEM_MISALIGN_TRAP_EN undefined: misaligned low bits are forced to 0 and the access proceeds; err is driven only by timeout.

Verification
REQ-039 LB addr 0x103, dm_rdata 0x80000000, ack 2 cycles after BUSY entry -> wb_data 0xFFFFFF80, wb_valid 1 cycle, stall high 3 cycles.
REQ-040 SH addr 0x202, rs2 0x1234ABCD -> dm_be 4'b1100, dm_wdata 0xABCDABCD, dm_addr 0x200, dm_we=1.
REQ-041 Non-memory instruction, alu_out 0x55 -> wb_data 0x55 next cycle, stall never asserted.
REQ-042 LW with no ack, WAIT_MAX=15 -> dm_req high 15 cycles, then err=1 and wb_reg_write=0.
REQ-043 LW addr 0x101: with MEM_MISALIGN_TRAP_EN, err=1 and no dm_req; without it, dm_addr=0x100 and dm_be=4'b1111.
REQ-044 rst=0 in the 2nd BUSY cycle -> dm_req=0 the next cycle, all outputs 0, and no wb_valid for the abandoned access.
